chip_spreader: RTL and testbench
================================

Name: chip_spreader

Overview:
- DSSS spreading stage directly downstream of the TX FIFO serializer.
- Consumes the serial bit stream and its bit strobe, packs 4 bits into an IEEE 802.15.4 symbol, and emits the 32-chip PN sequence for that symbol at a fixed chip rate.
- Produces a serial chip output plus held O-QPSK I/Q chip rails for the modulator.
- Holds one pending symbol while the current one is being emitted, so back-to-back symbols leave no chip gaps.

Parameters:
- CHIP_DIV, 25, clk cycles per chip (50 MHz / 25 = 2 Mchip/s); legal range ≥2.
- CNT_W, 5, width of the chip-period counter; must hold CHIP_DIV-1.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  reset, synchronous, active-high despite the name.
- en  in  1  block enable; low clears the bit assembler and the pending symbol.
- bit_in  in  1  serial data bit from the TX FIFO; valid when bit_valid=1.
- bit_valid  in  1  one-cycle strobe qualifying bit_in.
- chip_out  out  1  current chip, held for CHIP_DIV cycles.
- chip_strobe  out  1  one-cycle pulse on the first cycle of each chip.
- i_chip  out  1  last even-indexed chip, held; O-QPSK I rail.
- q_chip  out  1  last odd-indexed chip, held; O-QPSK Q rail.
- busy  out  1  high while a symbol is being emitted.
- overrun  out  1  sticky; set when a symbol is lost; cleared only by reset.

Behaviour:
- Reset (reset_n=1 at a clk edge): all outputs 0, FSM=IDLE, bit count=0, pending_valid=0. Reset mid-symbol aborts emission immediately.
- Assembler:
  - On bit_valid=1 with en=1, bit_in is written to symbol bit [bit_cnt]; the first bit received is the LSB (b0).
  - bit_cnt wraps 3→0.
  - On the 4th bit, the nibble is written to the pending register and pending_valid is set.
  - If pending_valid is already 1 at that edge: the new nibble is dropped, the pending register is unchanged, and overrun is set.
- Chip table:
  - c0 is transmitted first.
  - Symbol 0 = 11011001110000110101001000101110 (c0..c31).
  - Symbols 1..7 = symbol 0 rotated right by 4k chips; symbol 1 = 11101101100111000011010100100010.
  - Symbols 8..15 = symbols 0..7 with odd-indexed chips inverted.
  - The table is a combinational ROM.
- FSM states:
  - IDLE: busy=0, chip_strobe=0, chip_out holds its last value. If pending_valid=1: load the 32-chip shift register from the ROM, clear pending_valid, chip_idx=0, period counter=0, go to EMIT.
  - EMIT: chip_out=shift[chip_idx]. The counter counts 0..CHIP_DIV-1; chip_strobe=1 when counter=0. At counter=CHIP_DIV-1, chip_idx increments.
  - At chip_idx=31 and counter=CHIP_DIV-1:
    - pending_valid=1: load the next symbol and stay in EMIT. The next cycle is c0 with chip_strobe=1, so there is no gap.
    - pending_valid=0: go to IDLE.
- Latency: 4th bit_valid in cycle t → pending_valid=1 in t+1 → (from IDLE) chip_strobe=1 with chip_out=c0 in t+2. The FSM consumes pending in the same edge the assembler may fill it; a fill and a consume on the same edge is legal and causes no overrun.
- I/Q rails: on each chip_strobe, even chip_idx loads i_chip and odd chip_idx loads q_chip; each rail holds between updates.
- Rate: 4 bits at 250 kb/s (200 clk per bit) = 800 clk per symbol = 32 × 25. The input therefore matches the output rate exactly, and one pending slot suffices.
- en=0:
  - Clears bit_cnt and pending_valid and ignores bit_valid.
  - The symbol currently in EMIT completes; the FSM then returns to IDLE.
  - overrun is unaffected.
- busy=1 from the first chip_strobe until the cycle the FSM returns to IDLE.

Test Plan:
- Reset, then 4 bits 0,0,0,0 at 200-clk spacing → chip_strobe 2 cycles after the 4th strobe; 32 chips equal 11011001110000110101001000101110; strobes 25 cycles apart; busy falls 800 cycles after the first strobe.
- Bits 1,0,0,0 (symbol 1) → chips 11101101100111000011010100100010; i_chip follows c0,c2,…; q_chip follows c1,c3,….
- Bits 1,1,1,1 (symbol 15) → symbol 7 sequence with odd chips inverted; check c1=NOT(symbol 7 c1).
- Continuous stream of 16 symbols 0..15 at the 250 kb/s rate → 512 contiguous chips, no gaps (every strobe exactly 25 cycles apart), overrun=0.
- Bits at 10-clk spacing, 12 bits → 1st symbol emitting, 2nd pending, 3rd dropped; overrun=1; only 64 chips emitted.
- Reset asserted at chip 10 of a symbol → next cycle busy=0, chip_out=0, chip_strobe=0; a following 4-bit input restarts cleanly at c0.

Source files
------------

// File: rtl/chip_spreader_if.sv
// Serial bit input and chip/rail outputs of the DSSS spreader.
// The master drives the data stream; the slave is the spreader itself.
interface chip_spreader_if;
  logic en;
  logic bit_in;
  logic bit_valid;
  logic chip_out;
  logic chip_strobe;
  logic i_chip;
  logic q_chip;
  logic busy;
  logic overrun;

  modport master (
    output en, bit_in, bit_valid,
    input  chip_out, chip_strobe, i_chip, q_chip, busy, overrun
  );

  modport slave (
    input  en, bit_in, bit_valid,
    output chip_out, chip_strobe, i_chip, q_chip, busy, overrun
  );
endinterface

// File: rtl/chip_spreader.sv
// IEEE 802.15.4 DSSS spreader: packs 4 serial bits into a symbol and emits its
// 32-chip PN sequence at CHIP_DIV clocks per chip, with one pending-symbol slot.
module chip_spreader #(
  parameter int unsigned CHIP_DIV = 25,
  parameter int unsigned CNT_W    = 5
) (
  input logic            clk,
  input logic            reset_n,
  chip_spreader_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Symbol 0 with bit i holding chip c_i (c0 at the LSB).
  localparam logic [31:0] SYM0 = 32'b01110100010010101100001110011011;

  // Symbols 1..7 delay the chip sequence by 4k chips; 8..15 also invert odd chips.
  function automatic logic [31:0] chip_rom(input logic [3:0] sym);
    logic [63:0] dbl;
    logic [31:0] rot;
    dbl = {SYM0, SYM0} << {sym[2:0], 2'b00};
    rot = dbl[63:32];
    return sym[3] ? (rot ^ 32'hAAAA_AAAA) : rot;
  endfunction

  state_t           state;
  logic [1:0]       bit_cnt;
  logic [2:0]       asm_bits;
  logic [3:0]       pending;
  logic             pending_valid;
  logic [31:0]      shift;
  logic [4:0]       chip_idx;
  logic [CNT_W-1:0] cnt;
  logic             chip_out_r;
  logic             chip_strobe_r;
  logic             i_chip_r;
  logic             q_chip_r;
  logic             busy_r;
  logic             overrun_r;

  logic             fill;
  logic             chip_end;
  logic             consume;
  logic [3:0]       nibble;
  logic [31:0]      rom_word;
  logic [4:0]       next_idx;

  always_comb begin
    fill     = bus.en && bus.bit_valid && (bit_cnt == 2'd3);
    nibble   = {bus.bit_in, asm_bits};
    chip_end = (state == EMIT) && (cnt == CNT_W'(CHIP_DIV - 1));
    consume  = pending_valid && ((state == IDLE) || (chip_end && chip_idx == 5'd31));
    rom_word = chip_rom(pending);
    next_idx = chip_idx + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      asm_bits      <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      shift         <= '0;
      chip_idx      <= '0;
      cnt           <= '0;
      chip_out_r    <= 1'b0;
      chip_strobe_r <= 1'b0;
      i_chip_r      <= 1'b0;
      q_chip_r      <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      if (!bus.en) begin
        bit_cnt       <= '0;
        pending_valid <= 1'b0;
      end else begin
        if (bus.bit_valid) begin
          bit_cnt  <= bit_cnt + 2'd1;
          asm_bits <= {bus.bit_in, asm_bits[2:1]};
        end
        // A fill coinciding with a consume refills the slot without loss.
        if (fill && (!pending_valid || consume)) begin
          pending       <= nibble;
          pending_valid <= 1'b1;
        end else if (consume) begin
          pending_valid <= 1'b0;
        end
        if (fill && pending_valid && !consume)
          overrun_r <= 1'b1;
      end

      if (consume) begin
        state         <= EMIT;
        shift         <= rom_word;
        chip_idx      <= '0;
        cnt           <= '0;
        chip_out_r    <= rom_word[0];
        i_chip_r      <= rom_word[0];
        chip_strobe_r <= 1'b1;
        busy_r        <= 1'b1;
      end else if (chip_end) begin
        if (chip_idx == 5'd31) begin
          state         <= IDLE;
          busy_r        <= 1'b0;
          chip_strobe_r <= 1'b0;
        end else begin
          chip_idx      <= next_idx;
          cnt           <= '0;
          chip_out_r    <= shift[next_idx];
          chip_strobe_r <= 1'b1;
          if (next_idx[0])
            q_chip_r <= shift[next_idx];
          else
            i_chip_r <= shift[next_idx];
        end
      end else begin
        if (state == EMIT)
          cnt <= cnt + CNT_W'(1);
        chip_strobe_r <= 1'b0;
      end
    end
  end

  assign bus.chip_out    = chip_out_r;
  assign bus.chip_strobe = chip_strobe_r;
  assign bus.i_chip      = i_chip_r;
  assign bus.q_chip      = q_chip_r;
  assign bus.busy        = busy_r;
  assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_chip_spreader.sv
// Randomized bench for chip_spreader against a string-based PN chip model.
module tb_chip_spreader;

  localparam int unsigned DIV = 25;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  chip_spreader_if bus ();

  chip_spreader #(.CHIP_DIV(DIV), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned cyc          = 0;
  int unsigned rise_cyc     = 0;
  int unsigned fall_cyc     = 0;
  int unsigned last_v       = 0;
  logic        busy_q       = 1'b0;

  logic        rec_chip[$];
  logic        rec_i[$];
  logic        rec_q[$];
  int unsigned rec_cyc[$];
  int unsigned exp_syms[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.chip_strobe === 1'b1) begin
      rec_chip.push_back(bus.chip_out);
      rec_i.push_back(bus.i_chip);
      rec_q.push_back(bus.q_chip);
      rec_cyc.push_back(cyc);
    end
    if (!busy_q && bus.busy === 1'b1) rise_cyc <= cyc;
    if (busy_q && bus.busy === 1'b0) fall_cyc <= cyc;
    busy_q <= (bus.busy === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chip i of symbol sym, read straight from the published chip string.
  function automatic logic ref_chip(input int unsigned sym, input int unsigned i);
    string       s0 = "11011001110000110101001000101110";
    int unsigned j  = (i + 32 - 4 * (sym % 8)) % 32;
    logic        c  = (s0.getc(j) == 8'h31);
    if (sym >= 8 && (i % 2) == 1) c = !c;
    return c;
  endfunction

  task automatic clear_rec();
    rec_chip.delete();
    rec_i.delete();
    rec_q.delete();
    rec_cyc.delete();
    exp_syms.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    check({tag, " chip_out"}, 32'(bus.chip_out), 32'd0);
    check({tag, " strobe"}, 32'(bus.chip_strobe), 32'd0);
    check({tag, " rails"}, {30'd0, bus.i_chip, bus.q_chip}, 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " overrun"}, 32'(bus.overrun), 32'd0);
    clear_rec();
    bus.en = 1'b1;
  endtask

  task automatic send_bit(input logic b, input int unsigned gap);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    last_v        = cyc;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_sym(input logic [3:0] s, input int unsigned gap);
    for (int b = 0; b < 4; b++) send_bit(s[b], gap);
  endtask

  task automatic wait_done(input string tag, input int unsigned n);
    int unsigned t = 0;
    while (!(rec_chip.size() >= n && bus.busy === 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " timeout"}, 32'(t < 3000), 32'd1);
    repeat (60) @(negedge clk);
  endtask

  task automatic verify(input string tag);
    int unsigned n      = exp_syms.size() * 32;
    int unsigned m      = (rec_chip.size() < n) ? rec_chip.size() : n;
    int unsigned gap_bad = 0;
    int unsigned iq_bad  = 0;
    logic [31:0] ow, ew;
    logic        prev;
    check({tag, " chips"}, rec_chip.size(), n);
    for (int unsigned s = 0; s < m / 32; s++) begin
      for (int unsigned i = 0; i < 32; i++) begin
        ow[i] = rec_chip[s * 32 + i];
        ew[i] = ref_chip(exp_syms[s], i);
      end
      check($sformatf("%s sym%0d(%0d)", tag, s, exp_syms[s]), ow, ew);
    end
    prev = 1'b0;
    for (int unsigned k = 0; k < m; k++) begin
      if (k > 0 && rec_cyc[k] - rec_cyc[k - 1] != DIV) gap_bad++;
      if (k % 2 == 0) begin
        if (rec_i[k] !== rec_chip[k] || rec_q[k] !== prev) iq_bad++;
      end else begin
        if (rec_q[k] !== rec_chip[k] || rec_i[k] !== prev) iq_bad++;
      end
      prev = rec_chip[k];
    end
    check({tag, " strobe spacing"}, gap_bad, 32'd0);
    check({tag, " iq rails"}, iq_bad, 32'd0);
  endtask

  initial begin
    logic [3:0]  r;
    logic [3:0]  a, b, c;
    int unsigned t;

    bus.en        = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;

    // Symbol 0 at the nominal bit rate: latency, chip sequence, busy window.
    do_reset("rst0");
    send_sym(4'd0, 200);
    exp_syms.push_back(0);
    wait_done("s0", 32);
    verify("s0");
    if (rec_cyc.size() > 0) begin
      check("s0 latency", rec_cyc[0] - last_v, 32'd2);
      check("s0 busy rise", rise_cyc, rec_cyc[0]);
      check("s0 busy fall", fall_cyc - rec_cyc[0], 32'd800);
    end

    do_reset("rst1");
    send_sym(4'd1, 200);
    exp_syms.push_back(1);
    wait_done("s1", 32);
    verify("s1");

    do_reset("rst15");
    send_sym(4'd15, 200);
    exp_syms.push_back(15);
    wait_done("s15", 32);
    verify("s15");
    if (rec_chip.size() > 1)
      check("s15 c1 inverted", 32'(rec_chip[1]), 32'(!ref_chip(7, 1)));

    // Back-to-back stream: all 16 symbols in order, then a random tail.
    do_reset("rst_stream");
    for (int unsigned s = 0; s < 16; s++) begin
      send_sym(4'(s), 200);
      exp_syms.push_back(s);
    end
    for (int k = 0; k < 6; k++) begin
      r = 4'($urandom_range(0, 15));
      send_sym(r, 200);
      exp_syms.push_back(r);
    end
    wait_done("stream", exp_syms.size() * 32);
    verify("stream");
    check("stream overrun", 32'(bus.overrun), 32'd0);

    // Bits far too fast: third symbol has nowhere to go.
    do_reset("rst_ovr");
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    c = 4'($urandom_range(0, 15));
    send_sym(a, 10);
    send_sym(b, 10);
    send_sym(c, 10);
    exp_syms.push_back(a);
    exp_syms.push_back(b);
    check("ovr flag", 32'(bus.overrun), 32'd1);
    wait_done("ovr", 64);
    verify("ovr");
    check("ovr sticky", 32'(bus.overrun), 32'd1);

    // Reset in the middle of chip 10, then a clean restart.
    do_reset("rst_mid");
    send_sym(4'($urandom_range(0, 15)), 1);
    t = 0;
    while (rec_chip.size() < 11 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("mid reach chip10", 32'(t < 2000), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid busy", 32'(bus.busy), 32'd0);
    check("mid chip_out", 32'(bus.chip_out), 32'd0);
    check("mid strobe", 32'(bus.chip_strobe), 32'd0);
    reset_n = 1'b0;
    clear_rec();
    r = 4'($urandom_range(0, 15));
    send_sym(r, 200);
    exp_syms.push_back(r);
    wait_done("restart", 32);
    verify("restart");
    if (rec_cyc.size() > 0)
      check("restart latency", rec_cyc[0] - last_v, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
